// File: rtl/mix_columns_seq.sv
// mix_columns_seq
//   Sequential AES MixColumns stage for a full 128-bit state. It captures a
//   state, transforms COLS_PER_CYCLE columns per clock in place, then holds
//   the result until the downstream stage accepts it.
//
//   Optional feature: define INV_MIX_EN to compile the InvMixColumns datapath.
//   When it is undefined, in_inv is ignored and only the forward transform
//   exists.
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   in_state/in_inv valid
//   in_ready   block can accept a state (IDLE)
//   in_state   column c = bits[32c+31:32c], row r = bits[32c+8r+7:32c+8r]
//   in_inv     0 = MixColumns, 1 = InvMixColumns
//   out_valid  out_state valid (DONE)
//   out_ready  downstream accepts out_state
//   out_state  transformed state, same layout as in_state
//   busy       FSM not in IDLE
//
// State | meaning
//   IDLE | waiting for an input state, in_ready high
//   RUN  | transforming one column group per cycle
//   DONE | result presented, waiting for out_ready
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1,
    parameter int NUM_COLS       = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int CNT_W = $clog2(NUM_COLS);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(COLS_PER_CYCLE);
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_COLS - COLS_PER_CYCLE);

    if ((COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) ||
        NUM_COLS != 4) begin : g_bad_param
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4 and NUM_COLS must be 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [127:0]       work;
    logic [127:0]       work_next;
    logic               accept;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0]  a [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) a[i] = col[8*i +: 8];
        r = '0;
        for (int i = 0; i < 4; i++) begin
            // 2*a_i ^ 3*a_{i+1} ^ a_{i+2} ^ a_{i+3}
            r[8*i +: 8] = xtime(a[i]) ^ xtime(a[(i+1)%4]) ^ a[(i+1)%4]
                        ^ a[(i+2)%4] ^ a[(i+3)%4];
        end
        return r;
    endfunction

`ifdef INV_MIX_EN
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[8*i +: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        r = '0;
        for (int i = 0; i < 4; i++) begin
            // e = 8^4^2, b = 8^2^1, d = 8^4^1, 9 = 8^1
            r[8*i +: 8] = (x8[i]       ^ x4[i]       ^ x2[i])
                        ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                        ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                        ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
        end
        return r;
    endfunction

    logic mode;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode <= 1'b0;
        end else if (accept) begin
            mode <= in_inv;
        end
    end
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
`endif

    // Only the current column group is rewritten; the counter is always a
    // multiple of COLS_PER_CYCLE so the group never runs past column 3.
    always_comb begin
        work_next = work;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
`ifdef INV_MIX_EN
            work_next[32*(int'(cnt)+g) +: 32] = mode ? mix_inv(work[32*(int'(cnt)+g) +: 32])
                                                     : mix_fwd(work[32*(int'(cnt)+g) +: 32]);
`else
            work_next[32*(int'(cnt)+g) +: 32] = mix_fwd(work[32*(int'(cnt)+g) +: 32]);
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_GRP) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            work <= '0;
            cnt  <= '0;
        end else if (accept) begin
            work <= in_state;
            cnt  <= '0;
        end else if (state == RUN) begin
            work <= work_next;
            cnt  <= cnt + CNT_STEP;
        end
    end

    // Partial results in RUN are never exposed.
    assign out_state = out_valid ? work : '0;

endmodule

// File: tb/tb_mix_columns_seq.sv
`timescale 1ns/1ps
module tb_mix_columns_seq;
    localparam int NDUT = 3;

    localparam logic [127:0] S1 = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db};
    localparam logic [127:0] R1 = {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};
    localparam logic [127:0] S2 = {32'h455313db, 32'h00000000, 32'h4c31262d, 32'hd5d4d4d4};
    localparam logic [127:0] R2 = {32'hbca14d8e, 32'h00000000, 32'hf8bd7e4d, 32'hd6d7d5d5};

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid  [NDUT];
    logic         in_ready  [NDUT];
    logic [127:0] in_state  [NDUT];
    logic         in_inv    [NDUT];
    logic         out_valid [NDUT];
    logic         out_ready [NDUT];
    logic [127:0] out_state [NDUT];
    logic         busy      [NDUT];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mix_columns_seq #(.COLS_PER_CYCLE(1 << g), .NUM_COLS(4)) u_dut (
            .clock     (clock),
            .reset_n   (reset_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    typedef struct {
        int           idx;
        logic [127:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every output handshake is matched against the oldest expectation.
    always @(negedge clock) begin
        if (reset_n) begin
            for (int k = 0; k < NDUT; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output dut%0d actual=%h required=none", k, out_state[k]);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check($sformatf("sb_dut_index dut%0d", k), 128'(k), 128'(mon_e.idx));
                        check($sformatf("sb_data dut%0d", k), out_state[k], mon_e.data);
                    end
                end
            end
        end
    end

    task automatic issue(input int k, input logic [127:0] st, input logic inv,
                         input logic [127:0] exp, input bit push, output bit ok);
        exp_t e;
        if (push) begin
            e.idx  = k;
            e.data = exp;
            sb_q.push_back(e);
        end
        in_valid[k] = 1'b1;
        in_state[k] = st;
        in_inv[k]   = inv;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (in_ready[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d actual=in_ready_low required=in_ready_high", k);
            in_valid[k] = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        // Scramble inputs right after capture; the DUT must ignore them.
        in_valid[k] = 1'b0;
        in_inv[k]   = ~inv;
        in_state[k] = ~st;
    endtask

    task automatic run_txn(input int k, input logic [127:0] st, input logic inv, input logic [127:0] exp);
        bit ok;
        int lat;
        int busy_cnt;
        out_ready[k] = 1'b1;
        issue(k, st, inv, exp, 1'b1, ok);
        if (!ok) return;
        lat = -1;
        busy_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (busy[k]) busy_cnt++;
            if (out_valid[k] && lat < 0) lat = n - 1;
            if (!busy[k]) break;
        end
        check($sformatf("latency dut%0d", k), 128'(lat), 128'(4 >> k));
        check($sformatf("busy_cycles dut%0d", k), 128'(busy_cnt), 128'((4 >> k) + 1));
        @(posedge clock);
        #1;
    endtask

    task automatic backpressure(input int k);
        bit ok;
        bit seen;
        out_ready[k] = 1'b0;
        issue(k, S1, 1'b0, R1, 1'b1, ok);
        if (!ok) return;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (out_valid[k]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL bp_wait_valid dut%0d actual=out_valid_low required=out_valid_high", k);
            out_ready[k] = 1'b1;
            return;
        end
        @(posedge clock);
        #1;
        for (int c = 0; c < 5; c++) begin
            in_valid[k] = ~c[0];
            in_state[k] = {$urandom, $urandom, $urandom, $urandom};
            in_inv[k]   = 1'($urandom_range(0, 1));
            @(negedge clock);
            check($sformatf("bp_out_state dut%0d", k), out_state[k], R1);
            check($sformatf("bp_in_ready dut%0d", k), 128'(in_ready[k]), 128'(0));
            check($sformatf("bp_out_valid dut%0d", k), 128'(out_valid[k]), 128'(1));
            @(posedge clock);
            #1;
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        check($sformatf("bp_release_in_ready dut%0d", k), 128'(in_ready[k]), 128'(1));
        check($sformatf("bp_release_out_valid dut%0d", k), 128'(out_valid[k]), 128'(0));
        @(posedge clock);
        #1;
    endtask

    task automatic reset_abort();
        bit ok;
        out_ready[0] = 1'b1;
        issue(0, S2, 1'b0, R2, 1'b0, ok);
        if (!ok) return;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", 128'(out_valid[0]), 128'(0));
        check("abort_out_state", out_state[0], 128'(0));
        check("abort_in_ready", 128'(in_ready[0]), 128'(1));
        check("abort_busy", 128'(busy[0]), 128'(0));
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        run_txn(0, S2, 1'b0, R2);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            in_valid[k]  = 1'b0;
            in_state[k]  = '0;
            in_inv[k]    = 1'b0;
            out_ready[k] = 1'b1;
        end
        #12;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("reset_in_ready dut%0d", k), 128'(in_ready[k]), 128'(1));
            check($sformatf("reset_out_valid dut%0d", k), 128'(out_valid[k]), 128'(0));
            check($sformatf("reset_out_state dut%0d", k), out_state[k], 128'(0));
            check($sformatf("reset_busy dut%0d", k), 128'(busy[k]), 128'(0));
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int k = 0; k < NDUT; k++) begin
            run_txn(k, S1, 1'b0, R1);
            run_txn(k, S2, 1'b0, R2);
`ifdef INV_MIX_EN
            run_txn(k, R1, 1'b1, S1);
            run_txn(k, R2, 1'b1, S2);
`else
            run_txn(k, S1, 1'b1, R1);
`endif
        end

        backpressure(0);
        backpressure(2);
        reset_abort();

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_empty", 128'(sb_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
